// File: rtl/exc_ctrl.sv
// Exception/ERET controller: picks the oldest pending exception or ERET, emits one-cycle
// CP0 write strobes and a PC redirect, and holds the matching stage flushes while the pipe drains.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_reserved,
  input  logic        id_syscall,
  input  logic        id_break,
  input  logic [31:0] id_pc,
  input  logic        id_bd,
  input  logic        exe_overflow,
  input  logic        exe_eret,
  input  logic [31:0] exe_pc,
  input  logic        exe_bd,
  input  logic        mem_adel,
  input  logic        mem_ades,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [31:0] status_out,
  input  logic [31:0] cause_out,
  input  logic [31:0] pc_back,
  output logic        write_epc,
  output logic        write_cause,
  output logic        write_status,
  output logic        write_bad,
  output logic [31:0] pc_in,
  output logic [31:0] cause_in,
  output logic [31:0] status_in,
  output logic [31:0] address,
  output logic        if_flush,
  output logic        id_flush,
  output logic        exe_flush,
  output logic        mem_flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXC = 2'd1, ERET = 2'd2, DRAIN = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_epc_q, write_epc_d, write_cause_q, write_cause_d;
  logic        write_status_q, write_status_d, write_bad_q, write_bad_d;
  logic [31:0] pc_in_q, pc_in_d, cause_in_q, cause_in_d;
  logic [31:0] status_in_q, status_in_d, address_q, address_d;
  logic        if_flush_q, if_flush_d, id_flush_q, id_flush_d;
  logic        exe_flush_q, exe_flush_d, mem_flush_q, mem_flush_d;
  logic        pc_redirect_q, pc_redirect_d, busy_q, busy_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        take_exc, take_eret, from_mem, from_exe, sel_bd;
  logic [4:0]  code;
  logic [31:0] sel_pc;

  // Priority select: older pipeline stages win; ERET ranks between EXE and ID exceptions.
  always_comb begin
    take_exc  = 1'b0;
    take_eret = 1'b0;
    from_mem  = 1'b0;
    from_exe  = 1'b0;
    code      = 5'h00;
    sel_pc    = 32'h0;
    sel_bd    = 1'b0;
    if (mem_adel || mem_ades) begin
      take_exc = 1'b1;
      from_mem = 1'b1;
      code     = mem_adel ? 5'h04 : 5'h05;
      sel_pc   = mem_pc;
      sel_bd   = mem_bd;
    end else if (exe_overflow) begin
      take_exc = 1'b1;
      from_exe = 1'b1;
      code     = 5'h0C;
      sel_pc   = exe_pc;
      sel_bd   = exe_bd;
    end else if (exe_eret) begin
      take_eret = 1'b1;
    end else if (id_reserved || id_syscall || id_break) begin
      take_exc = 1'b1;
      code     = id_reserved ? 5'h0A : (id_syscall ? 5'h08 : 5'h09);
      sel_pc   = id_pc;
      sel_bd   = id_bd;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    write_epc_d    = 1'b0;
    write_cause_d  = 1'b0;
    write_status_d = 1'b0;
    write_bad_d    = 1'b0;
    pc_redirect_d  = 1'b0;
    pc_in_d        = pc_in_q;
    cause_in_d     = cause_in_q;
    status_in_d    = status_in_q;
    address_d      = address_q;
    redirect_pc_d  = redirect_pc_q;
    if_flush_d     = if_flush_q;
    id_flush_d     = id_flush_q;
    exe_flush_d    = exe_flush_q;
    mem_flush_d    = mem_flush_q;
    case (state_q)
      IDLE: begin
        if_flush_d  = 1'b0;
        id_flush_d  = 1'b0;
        exe_flush_d = 1'b0;
        mem_flush_d = 1'b0;
        if (take_exc) begin
          state_d        = EXC;
          write_cause_d  = 1'b1;
          cause_in_d     = {sel_bd, cause_out[30:7], code, cause_out[1:0]};
          write_status_d = 1'b1;
          status_in_d    = status_out | 32'h2;
          write_epc_d    = ~status_out[1];
          pc_in_d        = sel_bd ? (sel_pc - 32'd4) : sel_pc;
          write_bad_d    = from_mem;
          if (from_mem) address_d = mem_addr;
          mem_flush_d    = from_mem;
          exe_flush_d    = from_mem | from_exe;
          id_flush_d     = 1'b1;
          if_flush_d     = 1'b1;
          pc_redirect_d  = 1'b1;
          redirect_pc_d  = EXC_VECTOR;
        end else if (take_eret) begin
          state_d        = ERET;
          write_status_d = 1'b1;
          status_in_d    = status_out & ~32'h2;
          exe_flush_d    = 1'b1;
          id_flush_d     = 1'b1;
          if_flush_d     = 1'b1;
          pc_redirect_d  = 1'b1;
          redirect_pc_d  = pc_back;
        end
      end
      EXC, ERET: begin
        if (DRAIN_CYCLES <= 1) begin
          state_d     = IDLE;
          if_flush_d  = 1'b0;
          id_flush_d  = 1'b0;
          exe_flush_d = 1'b0;
          mem_flush_d = 1'b0;
        end else begin
          state_d = DRAIN;
          cnt_d   = 4'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        // Requests seen here belong to flushed instructions and are dropped.
        if (cnt_q <= 4'd1) begin
          state_d     = IDLE;
          if_flush_d  = 1'b0;
          id_flush_d  = 1'b0;
          exe_flush_d = 1'b0;
          mem_flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      write_epc_q    <= 1'b0;
      write_cause_q  <= 1'b0;
      write_status_q <= 1'b0;
      write_bad_q    <= 1'b0;
      pc_in_q        <= 32'h0;
      cause_in_q     <= 32'h0;
      status_in_q    <= 32'h0;
      address_q      <= 32'h0;
      if_flush_q     <= 1'b0;
      id_flush_q     <= 1'b0;
      exe_flush_q    <= 1'b0;
      mem_flush_q    <= 1'b0;
      pc_redirect_q  <= 1'b0;
      redirect_pc_q  <= 32'h0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      write_epc_q    <= write_epc_d;
      write_cause_q  <= write_cause_d;
      write_status_q <= write_status_d;
      write_bad_q    <= write_bad_d;
      pc_in_q        <= pc_in_d;
      cause_in_q     <= cause_in_d;
      status_in_q    <= status_in_d;
      address_q      <= address_d;
      if_flush_q     <= if_flush_d;
      id_flush_q     <= id_flush_d;
      exe_flush_q    <= exe_flush_d;
      mem_flush_q    <= mem_flush_d;
      pc_redirect_q  <= pc_redirect_d;
      redirect_pc_q  <= redirect_pc_d;
      busy_q         <= busy_d;
    end
  end

  assign write_epc    = write_epc_q;
  assign write_cause  = write_cause_q;
  assign write_status = write_status_q;
  assign write_bad    = write_bad_q;
  assign pc_in        = pc_in_q;
  assign cause_in     = cause_in_q;
  assign status_in    = status_in_q;
  assign address      = address_q;
  assign if_flush     = if_flush_q;
  assign id_flush     = id_flush_q;
  assign exe_flush    = exe_flush_q;
  assign mem_flush    = mem_flush_q;
  assign pc_redirect  = pc_redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a vector table of single events (priority, delay slot, nested,
// ERET) followed by hand-written drain, back-to-back and reset-in-EXC sequences.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam logic [31:0] MEM_PC = 32'h00400008;
  localparam logic [31:0] EXE_PC = 32'h00400010;
  localparam logic [31:0] ID_PC  = 32'h00400024;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_reserved, id_syscall, id_break, id_bd;
  logic [31:0] id_pc;
  logic        exe_overflow, exe_eret, exe_bd;
  logic [31:0] exe_pc;
  logic        mem_adel, mem_ades, mem_bd;
  logic [31:0] mem_addr, mem_pc;
  logic [31:0] status_out, cause_out, pc_back;
  logic        write_epc, write_cause, write_status, write_bad;
  logic [31:0] pc_in, cause_in, status_in, address;
  logic        if_flush, id_flush, exe_flush, mem_flush;
  logic        pc_redirect, busy;
  logic [31:0] redirect_pc;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  exc_ctrl dut (
    .clk(clk), .reset(reset),
    .id_reserved(id_reserved), .id_syscall(id_syscall), .id_break(id_break),
    .id_pc(id_pc), .id_bd(id_bd),
    .exe_overflow(exe_overflow), .exe_eret(exe_eret), .exe_pc(exe_pc), .exe_bd(exe_bd),
    .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_addr(mem_addr), .mem_pc(mem_pc),
    .mem_bd(mem_bd),
    .status_out(status_out), .cause_out(cause_out), .pc_back(pc_back),
    .write_epc(write_epc), .write_cause(write_cause), .write_status(write_status),
    .write_bad(write_bad), .pc_in(pc_in), .cause_in(cause_in), .status_in(status_in),
    .address(address), .if_flush(if_flush), .id_flush(id_flush), .exe_flush(exe_flush),
    .mem_flush(mem_flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // req bits: {mem_adel, mem_ades, exe_overflow, exe_eret, id_reserved, id_syscall, id_break}
  // bds bits: {mem_bd, exe_bd, id_bd}; wr bits: {epc, cause, status, bad}
  // flush bits: {mem, exe, id, if}
  typedef struct {
    logic [6:0]  req;
    logic [2:0]  bds;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] maddr;
    logic [31:0] pback;
    logic [3:0]  exp_wr;
    logic [31:0] exp_pc_in;
    logic [31:0] exp_cause_in;
    logic [31:0] exp_status_in;
    logic [31:0] exp_address;
    logic [3:0]  exp_flush;
    logic [31:0] exp_redirect;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_busy(input string name);
    logic [0:0] e;
    e = exp_q.pop_front();
    chk(name, {31'h0, busy}, {31'h0, e});
  endtask

  task automatic clear_reqs();
    {mem_adel, mem_ades, exe_overflow, exe_eret, id_reserved, id_syscall, id_break} = 7'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".strobes"}, {28'h0, write_epc, write_cause, write_status, write_bad}, 32'h0);
    chk({tag, ".flushes"}, {28'h0, mem_flush, exe_flush, id_flush, if_flush}, 32'h0);
    chk({tag, ".redirect"}, {31'h0, pc_redirect}, 32'h0);
    chk({tag, ".busy"}, {31'h0, busy}, 32'h0);
    chk({tag, ".state"}, {30'h0, dbg_state}, 32'h0);
    chk({tag, ".pc_in"}, pc_in, 32'h0);
    chk({tag, ".cause_in"}, cause_in, 32'h0);
    chk({tag, ".status_in"}, status_in, 32'h0);
    chk({tag, ".address"}, address, 32'h0);
    chk({tag, ".redirect_pc"}, redirect_pc, 32'h0);
  endtask

  // Driver: one event, then check the EXC/ERET cycle, the drain cycle and the first IDLE cycle.
  task automatic run_vec(input int i);
    vec_t v;
    string t;
    v = vecs[i];
    t = $sformatf("v%0d", i);
    @(negedge clk);
    {mem_adel, mem_ades, exe_overflow, exe_eret, id_reserved, id_syscall, id_break} = v.req;
    {mem_bd, exe_bd, id_bd} = v.bds;
    status_out = v.status;
    cause_out  = v.cause;
    mem_addr   = v.maddr;
    pc_back    = v.pback;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    @(negedge clk);
    chk({t, ".wr"}, {28'h0, write_epc, write_cause, write_status, write_bad}, {28'h0, v.exp_wr});
    chk({t, ".pc_in"}, pc_in, v.exp_pc_in);
    chk({t, ".cause_in"}, cause_in, v.exp_cause_in);
    chk({t, ".status_in"}, status_in, v.exp_status_in);
    chk({t, ".address"}, address, v.exp_address);
    chk({t, ".flush"}, {28'h0, mem_flush, exe_flush, id_flush, if_flush}, {28'h0, v.exp_flush});
    chk({t, ".pc_redirect"}, {31'h0, pc_redirect}, 32'h1);
    chk({t, ".redirect_pc"}, redirect_pc, v.exp_redirect);
    chk({t, ".state"}, {30'h0, dbg_state}, v.exp_wr[2] ? 32'h1 : 32'h2);
    chk_busy({t, ".busy_evt"});
    clear_reqs();
    @(negedge clk);
    chk({t, ".drain_wr"}, {27'h0, write_epc, write_cause, write_status, write_bad, pc_redirect},
        32'h0);
    chk({t, ".drain_flush"}, {28'h0, mem_flush, exe_flush, id_flush, if_flush},
        {28'h0, v.exp_flush});
    chk({t, ".drain_state"}, {30'h0, dbg_state}, 32'h3);
    chk_busy({t, ".busy_drain"});
    @(negedge clk);
    chk({t, ".idle_flush"}, {28'h0, mem_flush, exe_flush, id_flush, if_flush}, 32'h0);
    chk({t, ".idle_state"}, {30'h0, dbg_state}, 32'h0);
    chk_busy({t, ".busy_idle"});
  endtask

  initial begin
    vecs[0]  = '{7'b0010000, 3'b000, 32'h0, 32'h300, 32'h1003, 32'h00400100, 4'b1110,
                 32'h00400010, 32'h330, 32'h2, 32'h0, 4'b0111, VEC};
    vecs[1]  = '{7'b0000100, 3'b001, 32'h0, 32'h0, 32'h1003, 32'h00400100, 4'b1110,
                 32'h00400020, 32'h80000028, 32'h2, 32'h0, 4'b0011, VEC};
    vecs[2]  = '{7'b0110010, 3'b000, 32'h0, 32'h0, 32'h1003, 32'h00400100, 4'b1111,
                 32'h00400008, 32'h14, 32'h2, 32'h1003, 4'b1111, VEC};
    vecs[3]  = '{7'b0010000, 3'b000, 32'h2, 32'h0, 32'h1003, 32'h00400100, 4'b0110,
                 32'h00400010, 32'h30, 32'h2, 32'h1003, 4'b0111, VEC};
    vecs[4]  = '{7'b0001000, 3'b000, 32'h3, 32'h0, 32'h1003, 32'h00400100, 4'b0010,
                 32'h00400010, 32'h30, 32'h1, 32'h1003, 4'b0111, 32'h00400100};
    vecs[5]  = '{7'b0001000, 3'b000, 32'h0, 32'h0, 32'h1003, 32'h00400200, 4'b0010,
                 32'h00400010, 32'h30, 32'h0, 32'h1003, 4'b0111, 32'h00400200};
    vecs[6]  = '{7'b1100000, 3'b100, 32'hFF01, 32'h0, 32'h2002, 32'h00400100, 4'b1111,
                 32'h00400004, 32'h80000010, 32'hFF03, 32'h2002, 4'b1111, VEC};
    vecs[7]  = '{7'b0000011, 3'b000, 32'h0, 32'h0, 32'hDEAD0000, 32'h00400100, 4'b1110,
                 32'h00400024, 32'h20, 32'h2, 32'h2002, 4'b0011, VEC};
    vecs[8]  = '{7'b0000001, 3'b110, 32'h0, 32'h0, 32'hDEAD0000, 32'h00400100, 4'b1110,
                 32'h00400024, 32'h24, 32'h2, 32'h2002, 4'b0011, VEC};
    vecs[9]  = '{7'b0001100, 3'b000, 32'h3, 32'h0, 32'hDEAD0000, 32'h00400300, 4'b0010,
                 32'h00400024, 32'h24, 32'h1, 32'h2002, 4'b0111, 32'h00400300};
    vecs[10] = '{7'b0011000, 3'b010, 32'h0, 32'h0, 32'hDEAD0000, 32'h00400100, 4'b1110,
                 32'h0040000C, 32'h80000030, 32'h2, 32'h2002, 4'b0111, VEC};

    reset = 1'b1;
    clear_reqs();
    {mem_bd, exe_bd, id_bd} = 3'b000;
    id_pc = ID_PC; exe_pc = EXE_PC; mem_pc = MEM_PC;
    mem_addr = 32'h0; status_out = 32'h0; cause_out = 32'h0; pc_back = 32'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i);

    // Request held through DRAIN is dropped there, then taken on the first IDLE edge.
    status_out = 32'h0; cause_out = 32'h0; {mem_bd, exe_bd, id_bd} = 3'b000;
    @(negedge clk);
    exe_overflow = 1'b1;
    @(negedge clk);
    chk("drain.exc_seen", {31'h0, write_cause}, 32'h1);
    clear_reqs();
    @(negedge clk);
    mem_adel = 1'b1;
    id_syscall = 1'b1;
    chk("drain.busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("drain.ignored_wr", {31'h0, write_cause}, 32'h0);
    chk("drain.ignored_busy", {31'h0, busy}, 32'h0);
    chk("drain.idle_flush", {31'h0, if_flush}, 32'h0);
    mem_adel = 1'b0;
    @(negedge clk);
    chk("b2b.write_cause", {31'h0, write_cause}, 32'h1);
    chk("b2b.cause_in", cause_in, 32'h20);
    chk("b2b.flush", {28'h0, mem_flush, exe_flush, id_flush, if_flush}, 32'h3);
    chk("b2b.write_bad", {31'h0, write_bad}, 32'h0);
    clear_reqs();
    repeat (2) @(negedge clk);
    chk("b2b.idle_busy", {31'h0, busy}, 32'h0);

    // Reset while in EXC discards everything.
    id_break = 1'b1;
    mem_addr = 32'h00003004;
    mem_adel = 1'b1;
    @(negedge clk);
    chk("rst_exc.write_bad", {31'h0, write_bad}, 32'h1);
    chk("rst_exc.state", {30'h0, dbg_state}, 32'h1);
    clear_reqs();
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_exc");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_exc.after_busy", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/ERET controller that drives the CP0 register file; it is the producer side of the CP0 write interface.
- Collects exception requests from the ID, EXE and MEM stages and selects the oldest one.
- Generates one-cycle CP0 write strobes with data (EPC, Cause, Status, BadVAddr), pipeline flushes and a PC redirect to the exception vector.
- Also executes ERET: clears Status.EXL and redirects to EPC.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target on any exception
DRAIN_CYCLES, 2, total cycles flushes are held per event (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
id_reserved  input  1  reserved-instruction request from ID
id_syscall  input  1  syscall request from ID
id_break  input  1  break request from ID
id_pc  input  32  PC of the ID instruction
id_bd  input  1  ID instruction is in a delay slot
exe_overflow  input  1  arithmetic overflow request from EXE
exe_eret  input  1  ERET present in EXE
exe_pc  input  32  PC of the EXE instruction
exe_bd  input  1  EXE instruction is in a delay slot
mem_adel  input  1  load/fetch address error from MEM
mem_ades  input  1  store address error from MEM
mem_addr  input  32  faulting data address
mem_pc  input  32  PC of the MEM instruction
mem_bd  input  1  MEM instruction is in a delay slot
status_out  input  32  current CP0 Status
cause_out  input  32  current CP0 Cause
pc_back  input  32  current CP0 EPC
write_epc, write_cause, write_status, write_bad  output  1 each  CP0 write strobes
pc_in  output  32  EPC write data
cause_in  output  32  Cause write data
status_in  output  32  Status write data
address  output  32  BadVAddr write data
if_flush, id_flush, exe_flush, mem_flush  output  1 each  stage flushes
pc_redirect  output  1  PC override strobe
redirect_pc  output  32  PC override target
busy  output  1  high whenever state is not IDLE

Behaviour:
- All outputs are registered. On reset: state=IDLE, every strobe, flush, pc_redirect and busy = 0, every data output = 0.
- States: IDLE, EXC, ERET, DRAIN.
- IDLE priority at each edge, highest first: mem_adel > mem_ades > exe_overflow > exe_eret > id_reserved > id_syscall > id_break.
- ExcCodes: AdEL=0x04, AdES=0x05, Ov=0x0C, RI=0x0A, Sys=0x08, Bp=0x09.
- Exception accepted at edge N (IDLE -> EXC). During cycle N+1, in state EXC:
  - write_cause=1; cause_in = {bd, cause_out[30:7], code[4:0], cause_out[1:0]}.
  - write_status=1; status_in = status_out | 32'h2 (sets EXL).
  - write_epc=1 only if status_out[1]==0 when sampled. pc_in = pc-4 if bd, else pc; pc and bd are those of the selected stage.
  - write_bad=1 and address=mem_addr only for AdEL/AdES; otherwise write_bad=0 and address holds its value.
  - Flush scope depends on the source stage:
    - MEM source: mem_flush, exe_flush, id_flush and if_flush all = 1.
    - EXE source: exe_flush, id_flush and if_flush = 1; mem_flush = 0.
    - ID source: id_flush and if_flush = 1.
  - pc_redirect=1, redirect_pc=EXC_VECTOR.
- ERET accepted at edge N (IDLE -> ERET). During cycle N+1:
  - write_status=1; status_in = status_out & ~32'h2.
  - No other CP0 writes.
  - exe_flush, id_flush and if_flush = 1.
  - pc_redirect=1, redirect_pc=pc_back sampled at edge N.
- From EXC or ERET:
  - If DRAIN_CYCLES==1, go to IDLE.
  - Otherwise go to DRAIN for DRAIN_CYCLES-1 cycles.
- In DRAIN: strobes and pc_redirect = 0; the same flush set is held; all requests are ignored (not queued).
- Leaving DRAIN -> IDLE: flushes = 0 in the first IDLE cycle. A request may be accepted on that same edge.
- Strobes and pc_redirect are exactly one-cycle pulses per event.
- Simultaneous requests: only the highest-priority one is taken. Lower-priority requests are dropped because their stages are flushed.
- Reset in any state forces IDLE with all outputs at reset value on the next cycle; no partial CP0 write is completed.
- ERET while status_out[1]==0 is still executed (EXL cleared, redirect to pc_back).

Test Plan:
- Overflow: exe_overflow=1, exe_pc=32'h00400010, exe_bd=0, status_out=0 -> next cycle:
  - write_epc=1, pc_in=32'h00400010
  - cause_in[6:2]=0x0C, status_in=32'h2
  - exe/id/if_flush=1, mem_flush=0
  - pc_redirect=1, redirect_pc=32'hBFC00380
  - busy for exactly 2 cycles
- Delay-slot RI: id_reserved=1, id_pc=32'h00400024, id_bd=1 -> next cycle:
  - pc_in=32'h00400020, cause_in[31]=1, cause_in[6:2]=0x0A
  - only id/if_flush=1
- Priority: mem_ades, exe_overflow and id_syscall asserted together, mem_addr=32'h00001003 ->
  - code 0x05, write_bad=1, address=32'h00001003, all four flushes
  - no second event afterwards
- Nested: status_out=32'h2 with exe_overflow -> write_epc=0, write_cause=1, write_status=1, redirect to EXC_VECTOR.
- ERET: exe_eret=1, pc_back=32'h00400100, status_out=32'h3 -> next cycle:
  - write_status=1, status_in=32'h1
  - redirect_pc=32'h00400100, write_epc=0
- Drain/reset:
  - Request during DRAIN -> ignored.
  - reset asserted in EXC -> all outputs 0 next cycle, state IDLE.
